// File: rtl/prog_mem_loader_pkg.sv
// Shared constants and helpers for the loadable instruction memory.
// Holds the text-segment base, the fetch NOP and the loader state codes.
package prog_mem_loader_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Returns word with byte b placed in little-endian lane (lane 0 = bits [7:0]).
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [7:0]  b,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte-stream load, status and CPU fetch signals of the instruction memory loader.
// master = host/fetch side, slave = loader.
interface prog_mem_loader_if #(
  parameter int DEPTH = 64
) ();

  localparam int WC_W = $clog2(DEPTH + 1);

  logic            start;
  logic            s_valid;
  logic [7:0]      s_data;
  logic            s_last;
  logic            s_ready;
  logic            busy;
  logic            done;
  logic            err;
  logic [WC_W-1:0] word_count;
  logic [31:0]     addr;
  logic [31:0]     q;

  modport master (
    output start, s_valid, s_data, s_last, addr,
    input  s_ready, busy, done, err, word_count, q
  );

  modport slave (
    input  start, s_valid, s_data, s_last, addr,
    output s_ready, busy, done, err, word_count, q
  );

endinterface

// File: rtl/prog_mem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and strobes each completed word.
// A final byte on lanes 0..2 completes the word early with the upper lanes left at zero.
module prog_mem_loader_byte_packer
  import prog_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] pack_q, pack_d;

  // Lanes above lane_q are always zero in pack_q, which gives the zero-fill for free.
  assign word_o       = lane_insert(pack_q, data_i, lane_q);
  assign word_valid_o = accept_i & (last_i | (lane_q == 2'd3));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (clear_i) begin
      lane_d = 2'd0;
      pack_d = '0;
    end else if (accept_i) begin
      if (word_valid_o) begin
        lane_d = 2'd0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = word_o;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Loadable instruction memory: byte-stream loader FSM, word write port and
// combinational CPU fetch port over the text segment at BASE_ADDR.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 64,
  parameter logic [31:0] BASE_ADDR  = TEXT_BASE
) (
  input logic              clk,
  input logic              rst_n,
  prog_mem_loader_if.slave bus
);

  localparam int WC_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]      state_q, state_d;
  logic            err_q, err_d;
  logic [WC_W-1:0] wc_q, wc_d;

  logic            in_load;
  logic            accept;
  logic            full;
  logic            word_valid;
  logic [31:0]     word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign in_load = (state_q == ST_LOAD);
  assign accept  = bus.s_valid & in_load;
  assign full    = (wc_q == WC_W'(DEPTH));

  // Bytes arriving once the memory is full are dropped before they reach the packer.
  prog_mem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (bus.start & ~in_load),
    .accept_i     (accept & ~full),
    .data_i       (bus.s_data),
    .last_i       (bus.s_last),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wc_d    = wc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
          wc_d    = '0;
        end
      end
      ST_LOAD: begin
        if (accept && full) err_d = 1'b1;
        if (word_valid)     wc_d  = wc_q + 1'b1;
        if (accept && bus.s_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
    end
  end

  // NOTE: the array has no reset; contents must survive rst_n and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (word_valid) mem[wc_q[AW-1:0]] <= word;
  end

  logic [29:0] fetch_idx;
  logic        fetch_hit;

  assign fetch_idx = 30'((bus.addr - BASE_ADDR) >> 2);
  assign fetch_hit = (bus.addr >= BASE_ADDR) && (fetch_idx < 30'(DEPTH));

  // The image is unstable while loading, so the CPU sees NOPs until the load ends.
  assign bus.q          = (!in_load && fetch_hit) ? mem[fetch_idx[AW-1:0]] : NOP_WORD;
  assign bus.s_ready    = in_load;
  assign bus.busy       = in_load;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.word_count = wc_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: a 64-word and a 4-word instance driven with
// directed and random byte images, checked against an array model of the text segment.
module tb_prog_mem_loader;
  import prog_mem_loader_pkg::*;

  localparam int DEPTH_A = 64;
  localparam int DEPTH_B = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_mem_loader_if #(.DEPTH(DEPTH_A)) if_a ();
  prog_mem_loader_if #(.DEPTH(DEPTH_B)) if_b ();

  prog_mem_loader #(.DEPTH(DEPTH_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  prog_mem_loader #(.DEPTH(DEPTH_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  logic        start_v [2];
  logic        valid_v [2];
  logic        last_v  [2];
  logic [7:0]  data_v  [2];
  logic [31:0] addr_v  [2];
  logic        fetch_req [2];

  logic        ready_w [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        err_w   [2];
  logic [31:0] wc_w    [2];
  logic [31:0] q_w     [2];

  assign if_a.start   = start_v[0];
  assign if_a.s_valid = valid_v[0];
  assign if_a.s_data  = data_v[0];
  assign if_a.s_last  = last_v[0];
  assign if_a.addr    = addr_v[0];
  assign if_b.start   = start_v[1];
  assign if_b.s_valid = valid_v[1];
  assign if_b.s_data  = data_v[1];
  assign if_b.s_last  = last_v[1];
  assign if_b.addr    = addr_v[1];

  assign ready_w[0] = if_a.s_ready;
  assign busy_w[0]  = if_a.busy;
  assign done_w[0]  = if_a.done;
  assign err_w[0]   = if_a.err;
  assign wc_w[0]    = 32'(if_a.word_count);
  assign q_w[0]     = if_a.q;
  assign ready_w[1] = if_b.s_ready;
  assign busy_w[1]  = if_b.busy;
  assign done_w[1]  = if_b.done;
  assign err_w[1]   = if_b.err;
  assign wc_w[1]    = 32'(if_b.word_count);
  assign q_w[1]     = if_b.q;

  // Reference model: the text segment as plain arrays plus per-load expectations.
  int          depth_of [2] = '{DEPTH_A, DEPTH_B};
  logic [31:0] ref_mem [2][DEPTH_A];
  bit          ref_wr  [2][DEPTH_A];
  int          n_acc   [2];

  typedef struct { int id; int wc; bit err; }                      done_exp_t;
  typedef struct { int id; int at; }                               err_exp_t;
  typedef struct { int id; logic [31:0] addr; logic [31:0] q; }    fetch_exp_t;

  done_exp_t  exp_done_q  [$];
  err_exp_t   exp_err_q   [$];
  fetch_exp_t exp_fetch_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_q(input int i, input logic [31:0] a, input bit busy_now);
    logic [31:0] idx;
    if (busy_now || a < TEXT_BASE) return NOP_WORD;
    idx = (a - TEXT_BASE) / 4;
    if (idx >= 32'(depth_of[i])) return NOP_WORD;
    return ref_mem[i][idx];
  endfunction

  // Monitor: compares whenever a DUT raises done/err or a fetch is presented.
  initial begin
    bit         prev_done [2];
    bit         prev_err  [2];
    done_exp_t  de;
    err_exp_t   ee;
    fetch_exp_t fe;
    prev_done = '{0, 0};
    prev_err  = '{0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done_w[i] && !prev_done[i]) begin
          if (exp_done_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_event: dut %0d raised done, none expected", i);
          end else begin
            de = exp_done_q.pop_front();
            check("done_dut", 32'(i), 32'(de.id));
            check("word_count", wc_w[i], 32'(de.wc));
            check("err_at_done", 32'(err_w[i]), 32'(de.err));
            check("busy_at_done", 32'(busy_w[i]), 32'd0);
          end
        end
        if (err_w[i] && !prev_err[i]) begin
          if (exp_err_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL err_event: dut %0d raised err, none expected", i);
          end else begin
            ee = exp_err_q.pop_front();
            check("err_dut", 32'(i), 32'(ee.id));
            check("err_byte_index", 32'(n_acc[i]), 32'(ee.at));
          end
        end
        if (fetch_req[i]) begin
          if (exp_fetch_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_event: dut %0d fetch with no expectation", i);
          end else begin
            fe = exp_fetch_q.pop_front();
            check($sformatf("fetch_q_%0d_%h", fe.id, fe.addr), q_w[i], fe.q);
          end
        end
        prev_done[i] = done_w[i];
        prev_err[i]  = err_w[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int i, input logic [31:0] a, input bit busy_now);
    fetch_exp_t fe;
    fe.id = i; fe.addr = a; fe.q = model_q(i, a, busy_now);
    exp_fetch_q.push_back(fe);
    addr_v[i]    = a;
    fetch_req[i] = 1'b1;
    tick();
    fetch_req[i] = 1'b0;
  endtask

  task automatic do_start(input int i, input bit junk);
    n_acc[i]   = 0;
    start_v[i] = 1'b1;
    if (junk) begin
      valid_v[i] = 1'b1; data_v[i] = 8'hFF; last_v[i] = 1'b1;
    end
    tick();
    start_v[i] = 1'b0; valid_v[i] = 1'b0; last_v[i] = 1'b0;
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input bit last,
                           input int gap_pct, input bit poke_start);
    while (int'($urandom_range(99)) < gap_pct) begin
      valid_v[i] = 1'b0;
      start_v[i] = poke_start ? 1'($urandom_range(1)) : 1'b0;
      tick();
    end
    valid_v[i] = 1'b1; data_v[i] = b; last_v[i] = last;
    start_v[i] = poke_start ? 1'($urandom_range(1)) : 1'b0;
    @(posedge clk);
    n_acc[i]++;
    #1;
    valid_v[i] = 1'b0; last_v[i] = 1'b0; start_v[i] = 1'b0;
  endtask

  task automatic run_load(input int i, input logic [7:0] img[$], input int gap_pct,
                          input bit poke_start, input bit junk);
    int          nb, nw, wr;
    logic [31:0] w;
    done_exp_t   de;
    err_exp_t    ee;
    nb = img.size();
    nw = (nb + 3) / 4;
    wr = (nw < depth_of[i]) ? nw : depth_of[i];
    for (int k = 0; k < wr; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < nb) w[8*j +: 8] = img[4*k + j];
      ref_mem[i][k] = w;
      ref_wr[i][k]  = 1'b1;
    end
    de.id = i; de.wc = wr; de.err = (nb > 4 * depth_of[i]);
    exp_done_q.push_back(de);
    if (de.err) begin
      ee.id = i; ee.at = 4 * depth_of[i] + 1;
      exp_err_q.push_back(ee);
    end
    do_start(i, junk);
    fetch(i, TEXT_BASE, 1'b1);
    for (int k = 0; k < nb; k++) send_byte(i, img[k], k == nb - 1, gap_pct, poke_start);
    for (int t = 0; t < 8 && !done_w[i]; t++) tick();
    check("done_reached", 32'(done_w[i]), 32'd1);
  endtask

  task automatic check_image(input int i);
    for (int k = 0; k < depth_of[i]; k++)
      if (ref_wr[i][k]) fetch(i, TEXT_BASE + 32'(4 * k) + 32'($urandom_range(3)), 1'b0);
  endtask

  function automatic void rand_img(output logic [7:0] img[$], input int len);
    img = {};
    for (int k = 0; k < len; k++) img.push_back(8'($urandom));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] img[$];
    logic [7:0] t1[$];
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 0; valid_v[i] = 0; last_v[i] = 0; data_v[i] = 0;
      addr_v[i] = 0; fetch_req[i] = 0; n_acc[i] = 0;
      for (int k = 0; k < DEPTH_A; k++) begin
        ref_mem[i][k] = '0; ref_wr[i][k] = 1'b0;
      end
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_s_ready", 32'(ready_w[i]), 32'd0);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
      check("rst_done", 32'(done_w[i]), 32'd0);
      check("rst_err", 32'(err_w[i]), 32'd0);
      check("rst_word_count", wc_w[i], 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Two full words, then fetch and out-of-range addresses.
    t1 = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(0, t1, 0, 1'b0, 1'b0);
    fetch(0, 32'h0040_0004, 1'b0);
    fetch(0, 32'h0040_0000, 1'b0);
    fetch(0, 32'h003F_FFFC, 1'b0);
    fetch(0, TEXT_BASE + 32'(4 * DEPTH_A), 1'b0);
    fetch(0, 32'h0040_0002, 1'b0);

    // Partial word with zero fill; start arrives with a byte that must be ignored.
    img = {8'hAA, 8'hBB, 8'hCC};
    run_load(0, img, 0, 1'b0, 1'b1);
    fetch(0, 32'h0040_0000, 1'b0);
    fetch(0, 32'h0040_0004, 1'b0);

    // Same image as the first load with valid gaps and start pulses inside LOAD.
    run_load(0, t1, 40, 1'b1, 1'b0);
    check_image(0);

    // Fill the whole 64-word memory exactly.
    rand_img(img, 4 * DEPTH_A);
    run_load(0, img, 10, 1'b0, 1'b0);
    check_image(0);

    repeat (6) begin
      rand_img(img, int'($urandom_range(1, 40)));
      run_load(0, img, int'($urandom_range(0, 50)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      check_image(0);
    end

    // Small memory: overflow, exact fill, and random lengths around the boundary.
    img = {};
    for (int k = 0; k < 20; k++) img.push_back(8'(k + 1));
    run_load(1, img, 0, 1'b0, 1'b0);
    check_image(1);
    fetch(1, TEXT_BASE + 32'(4 * DEPTH_B), 1'b0);
    rand_img(img, 4 * DEPTH_B);
    run_load(1, img, 20, 1'b0, 1'b0);
    check_image(1);
    repeat (4) begin
      rand_img(img, int'($urandom_range(1, 24)));
      run_load(1, img, int'($urandom_range(0, 40)), 1'b0, 1'b0);
      check_image(1);
    end

    // Reset after six bytes: word 0 written, word 1 keeps its previous contents.
    img = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start(0, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(0, img[k], 1'b0, 0, 1'b0);
    ref_mem[0][0] = 32'h4433_2211;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    check("midrst_done", 32'(done_w[0]), 32'd0);
    check("midrst_s_ready", 32'(ready_w[0]), 32'd0);
    check("midrst_word_count", wc_w[0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    fetch(0, 32'h0040_0000, 1'b0);
    fetch(0, 32'h0040_0004, 1'b0);

    repeat (2) tick();
    check("pending_done", 32'(exp_done_q.size()), 32'd0);
    check("pending_err", 32'(exp_err_q.size()), 32'd0);
    check("pending_fetch", 32'(exp_fetch_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
